// File: rtl/regfile_rename_pkg.sv
// Shared defaults and constants for the renamed architectural register file.
// Imported by the top module and by the per-port read mux.
package regfile_rename_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned REG_NUM_DEF = 32;
  localparam int unsigned TAG_W_DEF   = 4;
  localparam int unsigned NUM_RD_DEF  = 2;

  // Index of the hardwired zero register
  localparam int unsigned ZERO_REG = 0;

  // Active levels for reset and the enable/flush strobes
  localparam logic RST_ON = 1'b1;
  localparam logic EN_ON  = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: selects zero (x0 or reset), a matching commit bypass, or the
// stored value with its busy bit and producing ROB tag.
module regfile_rd_port
  import regfile_rename_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TAG_W  = TAG_W_DEF
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_reg_value,
  input  logic              i_reg_busy,
  input  logic [TAG_W-1:0]  i_reg_tag,
  input  logic              i_commit_en,
  input  logic [ADDR_W-1:0] i_commit_rd,
  input  logic [TAG_W-1:0]  i_commit_tag,
  input  logic [XLEN-1:0]   i_commit_value,
  output logic [XLEN-1:0]   o_value_c,
  output logic              o_busy_c,
  output logic [TAG_W-1:0]  o_tag_c
);

  logic w_is_zero;
  logic w_bypass;

  assign w_is_zero = (i_addr == ADDR_W'(ZERO_REG));
  // Bypass only when the committing entry is the one this register waits on
  assign w_bypass  = (i_commit_en == EN_ON) && (i_commit_rd == i_addr) &&
                     i_reg_busy && (i_reg_tag == i_commit_tag);

  always_comb begin
    o_value_c = i_reg_value;
    o_busy_c  = i_reg_busy;
    o_tag_c   = i_reg_tag;
    if ((i_rst == RST_ON) || w_is_zero) begin
      o_value_c = '0;
      o_busy_c  = 1'b0;
      o_tag_c   = '0;
    end else if (w_bypass) begin
      o_value_c = i_commit_value;
      o_busy_c  = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural integer register file with per-register rename status
// (busy bit + ROB tag), commit writeback and single-cycle flush.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  parameter int unsigned ADDR_W  = $clog2(REG_NUM),
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned NUM_RD  = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_value,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic                     commit_en,
  input  logic [ADDR_W-1:0]        commit_rd,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic [XLEN-1:0]          commit_value,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [XLEN-1:0]   r_regs [REG_NUM];
  logic [TAG_W-1:0]  r_tag  [REG_NUM];
  logic [REG_NUM-1:0] r_busy;
  logic [CNT_W-1:0]  r_busy_count;

  logic               w_issue_ok;
  logic               w_commit_ok;
  logic [REG_NUM-1:0] w_busy_next;
  logic [CNT_W-1:0]   w_busy_cnt;
  logic [ADDR_W-1:0]  w_addr [NUM_RD];

  assign w_issue_ok  = (issue_en == EN_ON) && (issue_rd != ADDR_W'(ZERO_REG)) &&
                       (flush != EN_ON);
  assign w_commit_ok = (commit_en == EN_ON) && (commit_rd != ADDR_W'(ZERO_REG));

  // Busy update order: commit clear, then issue set, then flush wipes all
  always_comb begin
    w_busy_next = r_busy;
    if (w_commit_ok && r_busy[commit_rd] && (r_tag[commit_rd] == commit_tag)) begin
      w_busy_next[commit_rd] = 1'b0;
    end
    if (w_issue_ok) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    if (flush == EN_ON) begin
      w_busy_next = '0;
    end
    w_busy_next[ZERO_REG] = 1'b0;
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      w_busy_cnt = w_busy_cnt + CNT_W'(w_busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ON) begin
      r_regs       <= '{default: '0};
      r_tag        <= '{default: '0};
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_commit_ok) begin
        r_regs[commit_rd] <= commit_value;
      end
      if (w_issue_ok) begin
        r_tag[issue_rd] <= issue_tag;
      end
      r_busy       <= w_busy_next;
      r_busy_count <= w_busy_cnt;
    end
  end

  assign busy_count = r_busy_count;

  for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
    assign w_addr[g] = rd_addr[g*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W),
      .TAG_W  (TAG_W)
    ) u_rd_port (
      .i_rst          (rst),
      .i_addr         (w_addr[g]),
      .i_reg_value    (r_regs[w_addr[g]]),
      .i_reg_busy     (r_busy[w_addr[g]]),
      .i_reg_tag      (r_tag[w_addr[g]]),
      .i_commit_en    (commit_en),
      .i_commit_rd    (commit_rd),
      .i_commit_tag   (commit_tag),
      .i_commit_value (commit_value),
      .o_value_c      (rd_value[g*XLEN +: XLEN]),
      .o_busy_c       (rd_busy[g]),
      .o_tag_c        (rd_tag[g*TAG_W +: TAG_W])
    );
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural integer register file for the out-of-order RISC-V core, with per-register rename status (busy bit plus ROB tag).
- Decode/issue reads operands through NUM_RD read ports. Each port returns either a committed value or the ROB tag that will produce the value.
- The commit stage writes values back and clears rename status. A branch-mispredict flush clears all rename status in one cycle.

Parameters:
- XLEN, 32, data width of each register
- REG_NUM, 32, number of architectural registers (power of two)
- ADDR_W, $clog2(REG_NUM), register address width (derived; do not override)
- TAG_W, 4, ROB tag width
- NUM_RD, 2, number of read ports

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_value  out  NUM_RD*XLEN  read data per port
- rd_busy  out  NUM_RD  per port: 1 = value pending, use rd_tag
- rd_tag  out  NUM_RD*TAG_W  producing ROB tag per port (valid when rd_busy=1)
- issue_en  in  1  rename destination this cycle
- issue_rd  in  ADDR_W  destination register being renamed
- issue_tag  in  TAG_W  ROB tag allocated to issue_rd
- commit_en  in  1  commit writeback this cycle
- commit_rd  in  ADDR_W  committed destination
- commit_tag  in  TAG_W  ROB tag of the committing entry
- commit_value  in  XLEN  committed result
- flush  in  1  clear all rename status (mispredict)
- busy_count  out  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- **Reset** (rst=1 at posedge): all regs = 0, all busy = 0, all tags = 0, busy_count = 0. While rst=1, every rd_* output is 0.
- **Register x0:** hardwired.
  - Reads return value 0, busy 0, tag 0.
  - Issue and commit to x0 are ignored entirely.
- **Read ports:** combinational, zero latency, all ports independent.
  - Reads reflect state before this cycle's issue. An instruction reading its own destination sees the previous mapping.
  - Commit bypass on a read port: applies when commit_en=1, commit_rd==rd_addr, commit_rd!=0 and the reg is busy with tag==commit_tag. The port then returns rd_value=commit_value and rd_busy=0.
  - Commit whose tag does not match does not bypass: the port returns the stored value, busy=1 and the stored tag.
  - No read-side bypass from issue.
- **Commit** (posedge, commit_en=1, commit_rd!=0):
  - regs[commit_rd] <= commit_value, always (architectural state), regardless of tag match.
  - busy[commit_rd] <= 0 only if busy=1 and tag==commit_tag, and the rename is not overridden by the issue or flush rules below.
- **Issue** (posedge, issue_en=1, issue_rd!=0, flush=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag.
- **Issue and commit same register, same cycle:**
  - Issue wins on busy/tag: the register stays busy with issue_tag.
  - The value is still written.
- **Flush** (posedge):
  - All busy <= 0.
  - Any issue in the same cycle is dropped.
  - A commit in the same cycle still writes its value.
  - Tags keep their old values; they are don't-care while busy=0.
- **busy_count:**
  - Registered; equals the population of the busy bits after each posedge.
  - Becomes 0 the cycle after a flush or reset.
  - Range 0..REG_NUM-1, because x0 is never busy.
- **Priority at posedge:** rst > flush > issue > commit-clear. The value write is independent of this order.
- **Reset mid-operation:** issue, commit and flush in the reset cycle are all ignored.

Decomposition:
- Shared package/defines file: XLEN, REG_NUM, TAG_W defaults; zero-word and zero-reg constants; rst/enable level macros, extended consistently with the existing defines.
- One sub-module is natural: regfile_rd_port, the per-port mux holding the x0 / commit-bypass / busy-tag selection. It is instantiated NUM_RD times via generate.
- Storage and the busy/tag arrays stay in the top module.

Test Plan:
- Reset then read x1..x31 on both ports -> value 0, busy 0, busy_count 0. Issue x0 tag 3 -> x0 still busy 0.
- Issue x5 tag 7, next cycle read x5 -> busy 1, tag 7, busy_count 1. Commit x5 tag 7 value 0xDEADBEEF with a same-cycle read of x5 -> bypass returns 0xDEADBEEF, busy 0. Next cycle stored value 0xDEADBEEF, busy 0.
- Issue x6 tag 2, then issue x6 tag 9, then commit x6 tag 2 value 0x11 -> x6 value 0x11, busy 1, tag 9. Same-cycle read gives no bypass (busy 1, tag 9).
- Same cycle: issue x8 tag 4 and commit x8 with its old tag 1 and value 0x55 -> next cycle x8 value 0x55, busy 1, tag 4.
- Rename x1..x10 (busy_count 10), then flush with simultaneous issue x3 tag 5 and commit x2 value 0x22 -> all busy 0, busy_count 0, x2 value 0x22, x3 not busy.
- NUM_RD=4, TAG_W=6 instance: all four ports reading distinct busy registers -> per-port tags correct. Assert rst mid-stream -> all state zero next cycle.
